// File: rtl/fpf_encoder_seq.sv
// fpf_encoder_seq -- iterative Fibonacci-numeral-system forbidden-pattern-free
// (FPF) CAC encoder. It resolves one code bit per clock cycle, MSB first. The
// resulting N-bit codeword contains no 010 or 101 substring, and bit i has
// weight F(i+1), where F(1)=F(2)=1.
//
// Ports:
//   clock      in   system clock, posedge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input word valid
//   in_ready   out  encoder can take in_data this cycle
//   in_data    in   [DW-1:0] binary value to encode
//   out_valid  out  codeout/err valid
//   out_ready  in   downstream accepts the result
//   codeout    out  [N-1:0] FPF codeword
//   err        out  in_data >= F(N+2) (unrepresentable)

package fpf_encoder_seq_pkg;
    // Fibonacci number F(k), with F(1)=F(2)=1. Used at elaboration time only.
    function automatic longint unsigned fib(input int k);
        longint unsigned a, b, t;
        a = 1;
        b = 1;
        for (int i = 3; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction
endpackage

module fpf_encoder_seq
    import fpf_encoder_seq_pkg::*;
#(
    parameter  int N  = 38,
    localparam int DW = $clog2(fib(N + 2))
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  codeout,
    output logic          err
);

    localparam int IW = $clog2(N);
    localparam int RW = DW + 1;

    localparam logic [RW-1:0] F_LIM = RW'(fib(N + 2));
    localparam logic [RW-1:0] F_HI0 = RW'(fib(N + 1));
    localparam logic [RW-1:0] F_LO0 = RW'(fib(N));
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [RW-1:0] fhi_q, fhi_d;   // F(idx+2)
    logic [RW-1:0] flo_q, flo_d;   // F(idx+1): weight of the bit being resolved
    logic [IW-1:0] idx_q, idx_d;
    logic          prev_q, prev_d;
    logic [N-1:0]  code_q, code_d;
    logic          err_q, err_d;
    logic          accept;
    logic          bit_c;

    // DONE hands over directly to the next word when the result drains in
    // the same cycle, which gives one word per N+1 cycles.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign codeout   = code_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        fhi_d   = fhi_q;
        flo_d   = flo_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        code_d  = code_q;
        err_d   = err_q;
        bit_c   = 1'b0;

        case (state_q)
            RUN: begin
                if (idx_q == IDX_TOP) begin
                    bit_c = (rem_q >= fhi_q);
                end else if (idx_q == '0) begin
                    // Here the remainder has been reduced to 0 or 1.
                    bit_c = rem_q[0];
                end else if (rem_q < flo_q) begin
                    bit_c = 1'b0;
                end else if (rem_q >= fhi_q) begin
                    bit_c = 1'b1;
                end else begin
                    // Either choice is representable, so repeat the previous
                    // bit. This prevents an isolated 010/101 from forming.
                    bit_c = prev_q;
                end
                if (bit_c) begin
                    rem_d = rem_q - flo_q;
                end
                prev_d = bit_c;
                // Step the weights down by recurrence instead of using a ROM.
                fhi_d  = flo_q;
                flo_d  = fhi_q - flo_q;
                idx_d  = idx_q - IW'(1);
                code_d = {code_q[N-2:0], bit_c};
                if (idx_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            rem_d   = {1'b0, in_data};
            fhi_d   = F_HI0;
            flo_d   = F_LO0;
            idx_d   = IDX_TOP;
            prev_d  = 1'b0;
            code_d  = '0;
            err_d   = ({1'b0, in_data} >= F_LIM);
            state_d = err_d ? DONE : RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            fhi_q   <= '0;
            flo_q   <= '0;
            idx_q   <= '0;
            prev_q  <= 1'b0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fhi_q   <= fhi_d;
            flo_q   <= flo_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fpf_encoder_seq.sv
// Bench for fpf_encoder_seq with N=8 (DW=6, F(10)=55). It covers:
//   - directed vectors, including out-of-range words;
//   - back-pressure followed by a same-cycle hand-over;
//   - a reset in the middle of a conversion;
//   - a full 0..54 sweep with random output stalls.
module tb_fpf_encoder_seq;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] codeout;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fpf_encoder_seq #(.N(8)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeout   (codeout),
        .err       (err)
    );

    typedef struct {
        logic [5:0] din;
        logic [7:0] code;
        logic       e;
        int         lat;   // posedges after the accepting edge until out_valid
    } vec_t;

    vec_t vecs[8];

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Call this at #1 after a posedge while the DUT is in IDLE. The task
    // accepts din, counts cycles to out_valid, stalls, then samples and drains.
    task automatic run_word(input logic [5:0] din, input int stall,
                            output logic [7:0] code, output logic e, output int lat);
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 6'($urandom);   // Must not affect the word in flight.
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        repeat (stall) begin
            @(posedge clock);
            #1;
        end
        code = codeout;
        e    = err;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic int decode(input logic [7:0] c);
        int w[8] = '{1, 1, 2, 3, 5, 8, 13, 21};
        int s = 0;
        for (int i = 0; i < 8; i++) if (c[i]) s += w[i];
        return s;
    endfunction

    function automatic bit has_fp(input logic [7:0] c);
        bit f = 0;
        for (int i = 0; i < 6; i++)
            if ((c[i+2] != c[i+1]) && (c[i+1] != c[i])) f = 1;
        return f;
    endfunction

    initial begin
        logic [7:0] code, prev_code;
        logic       e;
        int         lat;
        bit         seen;

        vecs[0] = '{6'd0,  8'h00, 1'b0, 8};
        vecs[1] = '{6'd54, 8'hFF, 1'b0, 8};
        vecs[2] = '{6'd33, 8'h7F, 1'b0, 8};
        vecs[3] = '{6'd34, 8'hC0, 1'b0, 8};
        vecs[4] = '{6'd55, 8'h00, 1'b1, 0};
        vecs[5] = '{6'd63, 8'h00, 1'b1, 0};
        vecs[6] = '{6'd1,  8'h01, 1'b0, 8};
        vecs[7] = '{6'd20, 8'h3F, 1'b0, 8};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst codeout", codeout, 0);
        chk("rst err", err, 0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst in_ready", in_ready, 1);

        // Directed vectors.
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("v%0d in_ready", k), in_ready, 1);
            run_word(vecs[k].din, 0, code, e, lat);
            chk($sformatf("v%0d din=%0d latency", k, vecs[k].din), lat, vecs[k].lat);
            chk($sformatf("v%0d din=%0d codeout", k, vecs[k].din), code, vecs[k].code);
            chk($sformatf("v%0d din=%0d err", k, vecs[k].din), e, vecs[k].e);
            chk($sformatf("v%0d drained", k), out_valid, 0);
        end

        // Back-pressure, then hand over in the same cycle that the result drains.
        in_data = 6'd20; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("bp latency", lat, 8);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp hold%0d codeout", c), codeout, 8'h3F);
            chk($sformatf("bp hold%0d in_ready", c), in_ready, 0);
            chk($sformatf("bp hold%0d out_valid", c), out_valid, 1);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 6'd34;
        #1;
        chk("bp handover in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp handover out_valid drop", out_valid, 0);
        chk("bp handover in_ready busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("bp second latency", lat, 8);
        chk("bp second codeout", codeout, 8'hC0);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;

        // Reset during RUN at idx=4. After the accept edge, three more edges
        // reach idx=4.
        in_data = 6'd54; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        chk("midrst in_ready", in_ready, 1);
        seen = 0;
        out_ready = 1'b1;
        repeat (12) begin
            @(posedge clock);
            #1;
            seen |= out_valid;
        end
        out_ready = 1'b0;
        chk("midrst no out_valid", seen, 0);
        run_word(6'd33, 0, code, e, lat);
        chk("midrst next codeout", code, 8'h7F);
        chk("midrst next latency", lat, 8);

        // Full sweep with random stalls: decode, pattern, monotonicity.
        prev_code = '0;
        for (int v = 0; v < 55; v++) begin
            run_word(6'(v), int'($urandom_range(0, 3)), code, e, lat);
            chk($sformatf("sweep %0d decode", v), decode(code), v);
            chk($sformatf("sweep %0d forbidden pattern", v), has_fp(code), 0);
            if (v > 0) chk($sformatf("sweep %0d monotone", v), code > prev_code, 1);
            prev_code = code;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpf_encoder_seq.md
Name: fpf_encoder_seq

Overview:
- Parametrised, iterative Fibonacci-numeral-system (FNS) forbidden-pattern-free (FPF) CAC encoder.
- Maps a binary value to an N-bit codeword that contains no 010 or 101 pattern. Each code bit is resolved in one clock cycle, MSB first.
- Replaces the fixed-width, fully combinational encoders.
- Sits between the bus-side data source and the TSV/wire driver stage, with valid/ready handshakes on both sides.

Parameters:
- N, 38, codeword width in bits; legal range 3..64.
- DW, derived localparam = ceil(log2(F(N+2))), input data width. Fibonacci weights use F(1)=F(2)=1; for N=38 this gives 27.

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input data valid.
- in_ready  out  1  encoder can accept in_data this cycle.
- in_data  in  DW  binary value to encode.
- out_valid  out  1  codeout/err valid.
- out_ready  in  1  downstream accepts the result.
- codeout  out  N  FPF codeword; bit i has weight F(i+1).
- err  out  1  in_data was out of range, i.e. >= F(N+2).

Behaviour:
- **Reset** (rst_n=0 at posedge): state=IDLE; out_valid=0, codeout=0, err=0; in_ready=1 from the next cycle. Reset mid-RUN aborts the conversion with no output.
- **FSM**: IDLE -> RUN -> DONE -> IDLE, or DONE -> RUN directly.
- **in_ready** = (state==IDLE) || (state==DONE && out_ready). A transfer occurs when in_valid && in_ready.
- **Accept**: load rem=in_data, idx=N-1, f_hi=F(N+1), f_lo=F(N), prev=0. Clear the code shift register. Latch err = (in_data >= F(N+2)).
  - If err: go straight to DONE with codeout=0 and err=1; latency is 1 cycle.
  - Otherwise go to RUN.
- **RUN**, one bit per cycle at index idx. The weight of bit idx is f_lo=F(idx+1).
  - idx==N-1: bit = (rem >= f_hi).
  - 1 <= idx < N-1: bit = 0 if rem < f_lo; else 1 if rem >= f_hi; else prev.
  - idx==0: bit = rem[0]; rem must be 0 or 1 here by construction.
  - If bit==1: rem <= rem - f_lo.
  - Then prev <= bit; f_hi <= f_lo; f_lo <= f_hi - f_lo; idx <= idx-1.
  - After the idx==0 cycle, go to DONE.
- **Timing**: codeout/out_valid register at the posedge ending the idx==0 cycle. Latency is N cycles from the accepting edge to out_valid=1. Throughput is one word per N+1 cycles when out_ready=1, since DONE->RUN is allowed in the same cycle.
- **DONE**: out_valid=1; codeout/err are held stable while out_ready=0.
  - out_ready=1 and no new accept: go to IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept: go to RUN (or DONE if the new word is an error); out_valid drops for the RUN cycles.
- **Widths**: rem, f_hi and f_lo are DW+1 bits. Subtraction never underflows for a legal input. The Fibonacci registers are stepped by recurrence only, so no ROM is needed.
- **Stability**: in_data is only sampled on accept. Changes while in_ready=0 have no effect.
- **Output property**: every legal output has no 010 or 101 substring. Decoding is sum(codeout[i]*F(i+1)) = in_data.

Test Plan (N=8, DW=6, F(10)=55):
- Reset, then in_data=0 -> out_valid after 8 cycles; codeout=0x00, err=0.
- in_data=54 -> codeout=0xFF; in_data=33 -> codeout=0x7F; in_data=34 -> codeout=0xC0. Each result appears exactly 8 cycles after accept.
- in_data=55 and in_data=63 -> err=1, codeout=0x00, out_valid 1 cycle after accept.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE. codeout stays stable and in_ready=0 throughout. Asserting out_ready with in_valid=1 accepts the next word in that same cycle.
- Assert rst_n=0 during RUN at idx=4 -> out_valid never asserts for that word. in_ready=1 on the cycle after rst_n returns to 1; the next word encodes correctly.
- Exhaustive sweep 0..54 with random out_ready stalls: each codeout decodes to its input, contains no 010/101, and is strictly monotone in input order.
